outport_reader: RTL and testbench

Consumer-side endpoint of the CPU's 6-bit `outport`. The CPU drives `outport` with no write strobe, so this block samples it every clock and detects value changes. Each new value is pushed into a small show-ahead FIFO, and a downstream display or debug client pops entries over a valid/ready handshake. It sits between `cpu` and the display/ROM-side logic, in the same clock domain as the CPU.

---
 rtl/outport_reader.sv | 160 ++++++++++++++++
 tb/tb_outport_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/outport_reader.sv
// outport_reader
//
// Consumer-side endpoint of the CPU's W-bit output port. The CPU has no write
// strobe, so the port is sampled every clock. Each change of value is pushed
// into a show-ahead FIFO that a downstream client drains over valid/ready.
//
// Optional feature (macro OUTPORT_TIMESTAMP_EN):
//   Defined   - a free-running TSW-bit cycle counter is kept, and each pushed
//               entry stores the counter value seen at its push edge.
//   Undefined - no counter and no timestamp storage; dout_ts is tied to 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   outport    in   [W]    CPU output port value
//   dout       out  [W]    FIFO head data (show-ahead)
//   dout_ts    out  [TSW]  FIFO head timestamp
//   dout_valid out         FIFO non-empty
//   dout_ready in          consumer accepts head entry
//   count      out  [$clog2(DEPTH)+1]  occupancy 0..DEPTH
//   overflow   out         sticky: a change was dropped while full
//   ovf_clr    in          synchronous clear of overflow (a new drop wins)
module outport_reader #(
  parameter int W     = 6,
  parameter int DEPTH = 8,
  parameter int TSW   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             outport,
  output logic [W-1:0]             dout,
  output logic [TSW-1:0]           dout_ts,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  last_q, last_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  logic change;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    s_d    = outport;
    change = (s_q != last_q);
    full   = (count_q == CW'(DEPTH));
    pop    = (count_q != '0) && dout_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push   = change && (!full || pop);
    drop   = change && full && !pop;

    // last_q follows every change, accepted or not, so a dropped value is
    // never retried.
    last_d   = change ? s_q : last_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end

    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = s_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q        <= '0;
      last_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      // Storage is cleared so the head reads 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      s_q        <= s_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign dout       = mem_q[rd_ptr_q];
  assign dout_valid = (count_q != '0);
  assign count      = count_q;
  assign overflow   = overflow_q;

`ifdef OUTPORT_TIMESTAMP_EN
  logic [TSW-1:0] ts_q, ts_d;
  logic [TSW-1:0] ts_mem_q [DEPTH];
  logic [TSW-1:0] ts_mem_d [DEPTH];

  always_comb begin
    // Free-running; wraps naturally at 2^TSW.
    ts_d = ts_q + TSW'(1);
    for (int i = 0; i < DEPTH; i++) begin
      ts_mem_d[i] = ts_mem_q[i];
    end
    if (push) begin
      ts_mem_d[wr_ptr_q] = ts_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ts_mem_q[i] <= '0;
      end
    end else begin
      ts_q <= ts_d;
      for (int i = 0; i < DEPTH; i++) begin
        ts_mem_q[i] <= ts_mem_d[i];
      end
    end
  end

  assign dout_ts = ts_mem_q[rd_ptr_q];
`else
  assign dout_ts = '0;
`endif

endmodule

// File: tb/tb_outport_reader.sv
module tb_outport_reader;

  localparam int W     = 6;
  localparam int DEPTH = 8;
  localparam int TSW   = 16;

  logic           clk;
  logic           reset;
  logic [W-1:0]   outport;
  logic [W-1:0]   dout;
  logic [TSW-1:0] dout_ts;
  logic           dout_valid;
  logic           dout_ready;
  logic [3:0]     count;
  logic           overflow;
  logic           ovf_clr;

  int checks = 0;
  int errors = 0;

  outport_reader #(.W(W), .DEPTH(DEPTH), .TSW(TSW)) dut (
    .clk        (clk),
    .reset      (reset),
    .outport    (outport),
    .dout       (dout),
    .dout_ts    (dout_ts),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", dout_valid); end
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++;
    if (dout !== 6'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
    checks++;
    if (dout_ts !== 16'h0) begin errors++; $display("FAIL reset_dout_ts got %h want 0000", dout_ts); end
  endtask

  task automatic test_single_change();
    outport = 6'h05;
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL single_latency1 valid got %0b want 0", dout_valid); end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", dout_valid); end
    checks++;
    if (dout !== 6'h05) begin errors++; $display("FAIL single_dout got %h want 05", dout); end
    repeat (4) @(negedge clk);
    checks++;
    if (count !== 4'd1) begin errors++; $display("FAIL single_hold_count got %0d want 1", count); end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain count %0d valid %0b want 0 0", count, dout_valid);
    end
    // ready while empty must not disturb anything
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL empty_ready count got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      outport = W'(i);
      @(negedge clk);
    end
    // 0x01..0x08 pushed; 0x09 attempted on the next edge
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_fill count %0d ovf %0b want 8 0", count, overflow);
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", count); end
    checks++;
    if (dout !== 6'h01) begin errors++; $display("FAIL ovf_head got %h want 01", dout); end
    repeat (2) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] exp_q [8];
    exp_q = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h2A};
    outport = 6'h2A;
    @(negedge clk);          // 0x2A now in s_q, FIFO still full
    dout_ready = 1'b1;       // pop and push share the next edge
    @(negedge clk);
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL fullpp_count got %0d want 8", count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got %0b want 0", overflow); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dout !== exp_q[k]) begin
        errors++; $display("FAIL drain_order[%0d] got %h want %h", k, dout, exp_q[k]);
      end
      @(negedge clk);
    end
    dout_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty count %0d valid %0b want 0 0", count, dout_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      outport = W'(6'h10 + i);
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (count !== 4'd5) begin errors++; $display("FAIL prereset_count got %0d want 5", count); end
    #2 reset = 1'b1;
    outport = 6'h00;
    #1;
    checks++;
    if (count !== 4'd0 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset count %0d valid %0b want 0 0", count, dout_valid);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL postreset_zero count got %0d want 0", count); end
    outport = 6'h3F;
    repeat (2) @(negedge clk);
    checks++;
    if (count !== 4'd1 || dout !== 6'h3F || dout_valid !== 1'b1) begin
      errors++; $display("FAIL postreset_push count %0d dout %h valid %0b want 1 3f 1", count, dout, dout_valid);
    end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL postreset_ovf got %0b want 0", overflow); end
  endtask

  task automatic test_timestamp();
    logic [TSW-1:0] ts1;
    logic [TSW-1:0] ts2;
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    outport = 6'h11;
    repeat (3) @(negedge clk);
    outport = 6'h12;
    repeat (2) @(negedge clk);
    checks++;
    if (count !== 4'd2) begin errors++; $display("FAIL ts_count got %0d want 2", count); end
    ts1 = dout_ts;
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    ts2 = dout_ts;
`ifdef OUTPORT_TIMESTAMP_EN
    checks++;
    if (TSW'(ts2 - ts1) !== 16'd3) begin
      errors++; $display("FAIL ts_delta got %0d want 3", TSW'(ts2 - ts1));
    end
`else
    checks++;
    if (ts1 !== 16'h0 || ts2 !== 16'h0) begin
      errors++; $display("FAIL ts_tied got %h %h want 0000 0000", ts1, ts2);
    end
`endif
  endtask

  initial begin
    reset      = 1'b0;
    outport    = '0;
    dout_ready = 1'b0;
    ovf_clr    = 1'b0;
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    test_reset();
    test_single_change();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    test_timestamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
